// File: rtl/reg_load_arbiter.sv
// Round-robin arbiter sharing the load port of a single register among N_REQ requesters.
// Each grant runs IDLE -> LOAD (reg_ld pulse) -> ACK (one-hot ack pulse) -> IDLE.
module reg_load_arbiter #(
    parameter int N_REQ  = 4,
    parameter int DATA_W = 3,
    parameter int ID_W   = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N_REQ-1:0]          req,
    input  logic [N_REQ*DATA_W-1:0]   data,
    output logic [N_REQ-1:0]          ack,
    output logic                      reg_ld,
    output logic [DATA_W-1:0]         reg_in,
    output logic [ID_W-1:0]           grant_id,
    output logic                      busy,
    output logic [1:0]                dbg_state
);

    // Handshake: req[i] is a level held until ack[i] pulses for one cycle;
    // data[i] is sampled only at the IDLE edge where requester i wins.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_ACK  = 2'd2
    } state_t;

    state_t                r_state;
    logic [ID_W-1:0]       r_ptr;
    logic [ID_W-1:0]       r_grant_id;
    logic [DATA_W-1:0]     r_reg_in;
    logic                  r_reg_ld;
    logic [N_REQ-1:0]      r_ack;
    logic                  r_busy;

    logic                  w_found;
    logic [ID_W-1:0]       w_win;
    logic [DATA_W-1:0]     w_win_data;
    logic [N_REQ-1:0]      w_ack_onehot;
    logic [ID_W-1:0]       w_ptr_next;

    // Two descending passes: indices below ptr first, then indices at/above ptr
    // override, so the final winner is the first pending index from ptr upward.
    always_comb begin
        w_found    = 1'b0;
        w_win      = '0;
        w_win_data = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (req[i] && (i < int'(r_ptr))) begin
                w_found    = 1'b1;
                w_win      = ID_W'(i);
                w_win_data = data[i*DATA_W +: DATA_W];
            end
        end
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (req[i] && (i >= int'(r_ptr))) begin
                w_found    = 1'b1;
                w_win      = ID_W'(i);
                w_win_data = data[i*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        w_ack_onehot = '0;
        for (int i = 0; i < N_REQ; i++) begin
            w_ack_onehot[i] = (r_grant_id == ID_W'(i));
        end
    end

    assign w_ptr_next = (r_grant_id == ID_W'(N_REQ - 1)) ? '0 : r_grant_id + ID_W'(1);

    // Outputs are registered alongside the state so they line up with it exactly.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= S_IDLE;
            r_ptr      <= '0;
            r_grant_id <= '0;
            r_reg_in   <= '0;
            r_reg_ld   <= 1'b0;
            r_ack      <= '0;
            r_busy     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_ack <= '0;
                    if (w_found) begin
                        r_reg_in   <= w_win_data;
                        r_grant_id <= w_win;
                        r_reg_ld   <= 1'b1;
                        r_busy     <= 1'b1;
                        r_state    <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    r_reg_ld <= 1'b0;
                    r_ack    <= w_ack_onehot;
                    r_state  <= S_ACK;
                end
                S_ACK: begin
                    r_ack   <= '0;
                    r_busy  <= 1'b0;
                    r_ptr   <= w_ptr_next;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_reg_ld <= 1'b0;
                    r_ack    <= '0;
                    r_busy   <= 1'b0;
                    r_state  <= S_IDLE;
                end
            endcase
        end
    end

    assign ack       = r_ack;
    assign reg_ld    = r_reg_ld;
    assign reg_in    = r_reg_in;
    assign grant_id  = r_grant_id;
    assign busy      = r_busy;
    assign dbg_state = r_state;

endmodule
